// File: rtl/uart_rx_os_pkg.sv
// Shared definitions for the oversampling UART: parity codes, FSM states,
// and width/divisor helpers. Kept separate so the transmitter can reuse them.
package uart_rx_os_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START      = 3'd1,
      ST_DATA       = 3'd2,
      ST_PARITY     = 3'd3,
      ST_STOP       = 3'd4,
      ST_BREAK_WAIT = 3'd5
   } rx_state_t;

   // Bits needed to hold 0..value-1; never less than 1.
   function automatic int clogb2(input int value);
      int v;
      int w;
      v = value - 1;
      w = 0;
      while (v > 0) begin
         w = w + 1;
         v = v >> 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

   // Clock cycles per sample tick, truncated, at least 1.
   function automatic int calc_div(input int clk_freq, input int baud, input int os);
      int d;
      d = clk_freq / (baud * os);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_os_baud_gen.sv
// Sample-tick generator: one tick every DIV enabled clocks, restartable so the
// sample phase can be aligned to the start edge.
module uart_rx_os_baud_gen
   import uart_rx_os_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int            CW       = clogb2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick_o = en_i && (cnt_q == CNT_LAST);

   // Divider counter: wraps to 0 on its terminal count, frozen while disabled.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote bit recovery, optional parity,
// 1/2 stop bits, break detection and a valid/ready output buffer.
//
// state       | meaning
// ST_IDLE     | waiting for a falling edge on the synchronised line
// ST_START    | verifying the start bit; a voted 1 is a false start
// ST_DATA     | shifting DATA_W bits in, LSB first
// ST_PARITY   | checking the parity bit
// ST_STOP     | checking stop bits; leaves at the last stop's decision point
// ST_BREAK_WAIT | after a break, waiting for one full bit time of idle line
module uart_rx_os
   import uart_rx_os_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUDRATE   = 9600,
   parameter int DATA_W     = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rxd_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic              parity_err_o,
   output logic              frame_err_o,
   output logic              break_det_o,
   output logic              overrun_o
);

   localparam int            DIV       = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
   localparam int            SW        = clogb2(OVERSAMPLE);
   localparam int            BW        = clogb2(DATA_W);
   localparam logic [SW-1:0] SAMP_LO   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] SAMP_HI   = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
   localparam logic          STOP2     = (STOP_BITS == 2);
   localparam logic          HAS_PAR   = (PARITY != PARITY_NONE);
   localparam logic          PAR_ODD   = (PARITY == PARITY_ODD);

   logic              rxd_s1_q, rxd_s2_q, rxd_prev_q;
   rx_state_t         state_q;
   logic [SW-1:0]     samp_q;
   logic [BW-1:0]     bit_idx_q;
   logic              stop_idx_q;
   logic [DATA_W-1:0] shift_q;
   logic              pe_q, fe_q, zero_q;
   logic              s_lo_q, s_mid_q;
   logic              commit_q;
   logic [DATA_W-1:0] cm_data_q;
   logic              cm_pe_q, cm_fe_q, cm_bd_q;
   logic [DATA_W-1:0] data_q;
   logic              valid_q, par_err_q, frm_err_q, brk_q, overrun_q;

   logic tick, decide, vote, start_det, cnt_clear;

   assign start_det = (state_q == ST_IDLE) && rxd_prev_q && !rxd_s2_q;
   // Idle-time measurement after a break restarts whenever the line is low.
   assign cnt_clear = start_det || ((state_q == ST_BREAK_WAIT) && !rxd_s2_q);
   assign decide    = tick && (samp_q == SAMP_HI);
   assign vote      = (s_lo_q & s_mid_q) | (s_lo_q & rxd_s2_q) | (s_mid_q & rxd_s2_q);

   uart_rx_os_baud_gen #(.DIV(DIV)) u_baud (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (cnt_clear),
      .en_i    (state_q != ST_IDLE),
      .tick_o  (tick)
   );

   // Two-stage synchroniser plus one history stage for edge detection.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_s1_q   <= rxd_i;
         rxd_s2_q   <= rxd_s1_q;
         rxd_prev_q <= rxd_s2_q;
      end
   end

   // Sample counter: position of the current tick within a bit period.
   always_ff @(posedge clk_i) begin
      if (rst_i || cnt_clear) begin
         samp_q <= '0;
      end else if (tick) begin
         samp_q <= (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
      end
   end

   // Receive FSM with voter capture, shifter and per-frame status staging.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
         zero_q     <= 1'b1;
         s_lo_q     <= 1'b1;
         s_mid_q    <= 1'b1;
         commit_q   <= 1'b0;
         cm_data_q  <= '0;
         cm_pe_q    <= 1'b0;
         cm_fe_q    <= 1'b0;
         cm_bd_q    <= 1'b0;
      end else begin
         commit_q <= 1'b0;
         if (tick && (samp_q == SAMP_LO))  s_lo_q  <= rxd_s2_q;
         if (tick && (samp_q == SAMP_MID)) s_mid_q <= rxd_s2_q;
         unique case (state_q)
            ST_IDLE: begin
               if (start_det) begin
                  state_q    <= ST_START;
                  bit_idx_q  <= '0;
                  stop_idx_q <= 1'b0;
                  pe_q       <= 1'b0;
                  fe_q       <= 1'b0;
                  zero_q     <= 1'b1;
               end
            end
            ST_START: begin
               if (decide) state_q <= vote ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               if (decide) begin
                  shift_q <= {vote, shift_q[DATA_W-1:1]};
                  if (vote) zero_q <= 1'b0;
                  if (bit_idx_q == BIT_LAST) begin
                     bit_idx_q <= '0;
                     state_q   <= HAS_PAR ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (decide) begin
                  if (vote) zero_q <= 1'b0;
                  pe_q    <= (^{shift_q, vote}) ^ PAR_ODD;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (decide) begin
                  if (!stop_idx_q && !vote && zero_q) begin
                     // Break: whole frame low; report once, then wait for idle.
                     cm_data_q <= '0;
                     cm_pe_q   <= 1'b0;
                     cm_fe_q   <= 1'b1;
                     cm_bd_q   <= 1'b1;
                     commit_q  <= 1'b1;
                     state_q   <= ST_BREAK_WAIT;
                  end else if (STOP2 && !stop_idx_q) begin
                     stop_idx_q <= 1'b1;
                     if (!vote) fe_q <= 1'b1;
                  end else begin
                     cm_data_q <= shift_q;
                     cm_pe_q   <= pe_q;
                     cm_fe_q   <= fe_q | !vote;
                     cm_bd_q   <= 1'b0;
                     commit_q  <= 1'b1;
                     state_q   <= ST_IDLE;
                  end
               end
            end
            ST_BREAK_WAIT: begin
               if (tick && (samp_q == SAMP_LAST) && rxd_s2_q) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Single-entry output buffer; a frame arriving while it is held is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         brk_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (commit_q) begin
            if (!valid_q || rx_ready_i) begin
               data_q    <= cm_data_q;
               par_err_q <= cm_pe_q;
               frm_err_q <= cm_fe_q;
               brk_q     <= cm_bd_q;
               valid_q   <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (valid_q && rx_ready_i) begin
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            brk_q     <= 1'b0;
         end
      end
   end

   assign rx_data_o    = data_q;
   assign rx_valid_o   = valid_q;
   assign parity_err_o = par_err_q;
   assign frame_err_o  = frm_err_q;
   assign break_det_o  = brk_q;
   assign overrun_o    = overrun_q;

endmodule
